serial_sum_decoder: RTL
=======================

Name: serial_sum_decoder

Overview:
- Bit-serial inverse of the full-adder datapath. Input is a sum stream S plus one known operand stream A, both LSB first. The block recovers the other operand B = S - A - 0 (mod 2^WIDTH) using a full-subtractor cell and a registered borrow.
- Deparallelises the result into a word and presents it through a valid/ready handshake.
- Sits on the receive side of serial-arithmetic links, where the adder side transmits sums.

Parameters:
- WIDTH, 8, word length in bits. Legal range is WIDTH >= 2.
- CNT_W, $clog2(WIDTH), width of the bit counter. Derived value; do not override.

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  synchronous active-low reset, sampled on the rising edge of clk
- in_valid  input  1  sum_bit, a_bit and in_first are valid this cycle
- in_ready  output  1  block accepts a beat this cycle
- in_first  input  1  beat is bit 0 (LSB) of a new word
- sum_bit  input  1  serial sum bit S[i]
- a_bit  input  1  serial known-operand bit A[i]
- out_valid  output  1  b_word and borrow_out are valid
- out_ready  input  1  downstream accepts the result
- b_word  output  WIDTH  recovered operand B
- borrow_out  output  1  final borrow. A value of 1 means S < A unsigned.
- frame_err  output  1  one-cycle pulse on a framing violation

Behaviour:
- Reset (rst_n == 0 at a clock edge):
  - state = COLLECT, cnt = 0, borrow = 0, shift register = 0.
  - b_word = 0, borrow_out = 0, out_valid = 0, frame_err = 0.
  - in_ready is 1 from the first cycle after reset.
  - Reset has priority over every other event. A partial word or a held result is discarded.
- Beat acceptance: a beat is accepted when in_valid && in_ready. No beat is consumed otherwise, and gaps in in_valid are legal.
- Subtractor cell on each accepted beat, with br = (cnt == 0) ? 0 : borrow:
  - d = S ^ A ^ br
  - borrow_next = (~S & A) | (~S & br) | (A & br)
  - The shift register shifts right with d entering at bit WIDTH-1. After WIDTH beats, bit 0 holds the LSB.
- State COLLECT:
  - in_ready = 1, out_valid = 0.
  - Non-final beat: cnt increments and borrow = borrow_next.
  - Beat with cnt == WIDTH-1:
    - b_word = the final shifted value.
    - borrow_out = borrow_next.
    - cnt = 0, borrow = 0, state goes to HOLD.
    - out_valid = 1 on the next cycle. Latency is 1 cycle from the last accepted beat.
- State HOLD:
  - in_ready = 0, out_valid = 1.
  - b_word and borrow_out are held stable.
  - On out_ready: state goes to COLLECT, out_valid = 0 the next cycle, in_ready = 1 the next cycle.
  - out_ready while in COLLECT is ignored.
  - Peak throughput is WIDTH+1 cycles per word.
- Framing rules:
  - An accepted beat with in_first = 1 always starts a new word. That beat is treated as cnt = 0 with br = 0, and cnt becomes 1 afterwards.
  - in_first = 1 while cnt != 0 (mid-word) discards the partial word and pulses frame_err for 1 cycle (registered, the cycle after acceptance). The beat itself is then processed as bit 0.
  - in_first = 0 while cnt == 0 is accepted as bit 0 with no error. in_first is a resync aid only.
  - With WIDTH = 1 semantics excluded, a beat that is both in_first and final cannot occur.
- Arithmetic: all operations are modulo 2^WIDTH. borrow_out equals the unsigned comparison S < A over the full word.
- Outputs are all registered. There is no combinational path from in_valid or out_ready to any output except in_ready, which is a function of state only.

Test Plan:
- WIDTH = 8, S = 0x5A, A = 0x23, fed LSB first on consecutive cycles with in_first on bit 0 -> out_valid rises 1 cycle after the 8th beat; b_word = 0x37, borrow_out = 0.
- S = 0x10, A = 0x20 -> b_word = 0xF0, borrow_out = 1. Then S = 0x00, A = 0x00 -> b_word = 0x00, borrow_out = 0. This confirms borrow is cleared between words.
- out_ready held low for 5 cycles after out_valid -> in_ready = 0 throughout, b_word and borrow_out stable, extra in_valid beats are not consumed. out_ready = 1 -> out_valid drops and in_ready = 1 on the next cycle.
- in_valid toggled 1/0 every cycle across a full word with S = 0xFF, A = 0x01 -> b_word = 0xFE, borrow_out = 0. The result is identical to the gap-free run.
- in_first asserted on the 4th beat, followed by a full 8-beat word S = 0x81, A = 0x80 -> frame_err pulses exactly 1 cycle; only one result, b_word = 0x01, borrow_out = 0.
- rst_n pulled low for 1 cycle after 5 beats, or while in HOLD -> next cycle out_valid = 0, b_word = 0, in_ready = 1. A following full word decodes correctly.

Source files
------------

// File: rtl/serial_sum_decoder.sv
// serial_sum_decoder: bit-serial full-subtractor that recovers B = S - A from
// LSB-first sum and known-operand streams. The result word is presented
// through a valid/ready handshake.
module serial_sum_decoder #(
  parameter int WIDTH = 8,
  parameter int CNT_W = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             in_first,
  input  logic             sum_bit,
  input  logic             a_bit,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] b_word,
  output logic             borrow_out,
  output logic             frame_err
);

  typedef enum logic {COLLECT, HOLD} state_t;

  state_t           state;
  logic [CNT_W-1:0] cnt;
  logic             borrow;
  logic [WIDTH-1:0] sreg;

  logic             accept;
  logic [CNT_W-1:0] eff_cnt;
  logic             br;
  logic             d;
  logic             borrow_next;
  logic             last_beat;
  logic [WIDTH-1:0] shifted;

  // Ready depends on state only, so it carries no path from in_valid/out_ready.
  assign in_ready = (state == COLLECT);
  assign accept   = in_valid && in_ready;

  // Subtractor cell. in_first forces bit 0, which also masks the stale borrow.
  always_comb begin
    eff_cnt     = in_first ? '0 : cnt;
    br          = (eff_cnt == '0) ? 1'b0 : borrow;
    d           = sum_bit ^ a_bit ^ br;
    borrow_next = (~sum_bit & a_bit) | (~sum_bit & br) | (a_bit & br);
    last_beat   = (eff_cnt == CNT_W'(WIDTH-1));
    shifted     = {d, sreg[WIDTH-1:1]};
  end

  // Collect/hold sequencer; every output except in_ready is registered here.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state      <= COLLECT;
      cnt        <= '0;
      borrow     <= 1'b0;
      sreg       <= '0;
      b_word     <= '0;
      borrow_out <= 1'b0;
      out_valid  <= 1'b0;
      frame_err  <= 1'b0;
    end else begin
      frame_err <= 1'b0;
      case (state)
        COLLECT: begin
          if (accept) begin
            sreg <= shifted;
            // A mid-word start marker drops the partial word; flag it.
            if (in_first && cnt != '0) frame_err <= 1'b1;
            if (last_beat) begin
              b_word     <= shifted;
              borrow_out <= borrow_next;
              cnt        <= '0;
              borrow     <= 1'b0;
              out_valid  <= 1'b1;
              state      <= HOLD;
            end else begin
              cnt    <= eff_cnt + 1'b1;
              borrow <= borrow_next;
            end
          end
        end
        HOLD: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            state     <= COLLECT;
          end
        end
        default: state <= COLLECT;
      endcase
    end
  end

endmodule
